// File: rtl/quad_step_decoder_if.sv
// Bundles the quadrature pins, clear and the decoded position/event outputs.
// The master side drives the pins and clear; the slave side is the decoder.
interface quad_step_decoder_if #(
   parameter int WIDTH = 4
);
   logic             enc_a;
   logic             enc_b;
   logic             clear;
   logic [WIDTH-1:0] position;
   logic             dir;
   logic             step;
   logic             wrap;
   logic             err;
   logic             err_sticky;

   modport master (
      output enc_a, enc_b, clear,
      input  position, dir, step, wrap, err, err_sticky
   );

   modport slave (
      input  enc_a, enc_b, clear,
      output position, dir, step, wrap, err, err_sticky
   );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: synchronises enc_a/enc_b, decodes up/down steps and
// keeps a mod-N position with wrap, single-cycle error and sticky error flags.
module quad_step_decoder #(
   parameter int N           = 10,
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   quad_step_decoder_if.slave bus
);
   localparam int               FW       = $clog2(SYNC_STAGES + 1);
   localparam logic [FW-1:0]    FILL_END = FW'(SYNC_STAGES);
   localparam logic [WIDTH-1:0] POS_MAX  = WIDTH'(N - 1);

   logic [SYNC_STAGES-1:0] sync_a;
   logic [SYNC_STAGES-1:0] sync_b;
   logic [1:0]             ab;
   logic [1:0]             prev_ab;
   logic                   primed;
   logic [FW-1:0]          fill;

   logic [WIDTH-1:0] position_q;
   logic             dir_q;
   logic             step_q;
   logic             wrap_q;
   logic             err_q;
   logic             err_sticky_q;

   logic is_up;
   logic is_down;
   logic is_illegal;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {sync_a[SYNC_STAGES-2:0], bus.enc_a};
         sync_b <= {sync_b[SYNC_STAGES-2:0], bus.enc_b};
      end
   end

   assign ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

   always_comb begin
      is_up   = 1'b0;
      is_down = 1'b0;
      case ({prev_ab, ab})
         4'b0010, 4'b1011, 4'b1101, 4'b0100: is_up   = 1'b1;
         4'b0001, 4'b0111, 4'b1110, 4'b1000: is_down = 1'b1;
         default: ;
      endcase
      is_illegal = ((prev_ab ^ ab) == 2'b11);
   end

   // Priming waits until the synchroniser holds real pin values, so the
   // reset zeros still in the pipe are never mistaken for a phase change.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_ab      <= 2'b00;
         primed       <= 1'b0;
         fill         <= '0;
         position_q   <= '0;
         dir_q        <= 1'b1;
         step_q       <= 1'b0;
         wrap_q       <= 1'b0;
         err_q        <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         step_q <= 1'b0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
         if (!primed) begin
            if (fill == FILL_END) begin
               prev_ab <= ab;
               primed  <= 1'b1;
            end else begin
               fill <= fill + 1'b1;
            end
         end else begin
            prev_ab <= ab;
            if (bus.clear) begin
               position_q   <= '0;
               err_sticky_q <= 1'b0;
            end else if (is_up) begin
               step_q <= 1'b1;
               dir_q  <= 1'b1;
               if (position_q == POS_MAX) begin
                  position_q <= '0;
                  wrap_q     <= 1'b1;
               end else begin
                  position_q <= position_q + 1'b1;
               end
            end else if (is_down) begin
               step_q <= 1'b1;
               dir_q  <= 1'b0;
               if (position_q == '0) begin
                  position_q <= POS_MAX;
                  wrap_q     <= 1'b1;
               end else begin
                  position_q <= position_q - 1'b1;
               end
            end else if (is_illegal) begin
               err_q        <= 1'b1;
               err_sticky_q <= 1'b1;
            end
         end
      end
   end

   assign bus.position   = position_q;
   assign bus.dir        = dir_q;
   assign bus.step       = step_q;
   assign bus.wrap       = wrap_q;
   assign bus.err        = err_q;
   assign bus.err_sticky = err_sticky_q;
endmodule
